fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
- Downstream stage of FFT_Fixed. Consumes the 512-point FFT output, which arrives in bit-reversed order as 16 samples per beat over 32 beats.
- Re-emits each frame in natural frequency order, 16 samples per beat.
- Ping-pong (two-bank) register buffer: one frame is written while the previous frame is read, so back-to-back frames stream without stalls.

Parameters:
- WIDTH, 13, signed bit width of each re/im sample (matches FFT_Fixed WIDTH_OUT).
- ARRAY, 16, samples per beat; power of two.
- NPOINT, 512, FFT length; power of two; BEATS = NPOINT/ARRAY = 32.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- din_en  in  1  input beat valid (driven by FFT_Fixed do_en).
- din_re  in  WIDTH x ARRAY  signed real samples, bit-reversed order.
- din_im  in  WIDTH x ARRAY  signed imaginary samples, bit-reversed order.
- dout_valid  out  1  output beat valid.
- dout_re  out  WIDTH x ARRAY  signed real samples, natural order.
- dout_im  out  WIDTH x ARRAY  signed imaginary samples, natural order.
- dout_sof  out  1  high on beat 0 of each output frame.

Behaviour:
- Reset: clk is the only clock; rstn asynchronous active-low. Clears dout_valid, dout_sof, dout_re, dout_im (all 0), wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0, full[1:0]=0, reader=IDLE. Bank contents are not reset.
- Write side:
  - Each edge with din_en=1 stores lane l of beat c=wr_cnt at natural index n = bitrev_log2(NPOINT)(c*ARRAY+l) in bank wr_bank.
  - wr_cnt increments modulo BEATS.
  - din_en=0 gaps are allowed mid-frame; wr_cnt holds.
  - On the edge storing beat BEATS-1: set full[wr_bank], toggle wr_bank, wr_cnt returns to 0.
- Read FSM (IDLE, READ):
  - IDLE -> READ when full[rd_bank]=1 (registered flag, so at the edge after the last write).
  - In READ, each edge loads dout_re/dout_im lane l from natural index rd_cnt*ARRAY+l of bank rd_bank and sets dout_valid=1; dout_sof=1 when rd_cnt=0.
  - On the edge loading beat BEATS-1: clear full[rd_bank], toggle rd_bank, rd_cnt=0.
  - After that edge: if full of the new rd_bank is already 1, stay in READ with zero-gap continuation; else go to IDLE.
  - In IDLE, dout_valid=0 and dout_sof=0; data registers hold their last value.
- Latency: the last input beat is sampled at edge t; output beat 0 is registered at edge t+1; beats are output at t+1..t+32 with no gaps.
- Overrun: cannot occur. Writes need at least 32 edges per frame and reads take exactly 32, so a bank is always drained before it is rewritten. This is an assertion target: full[wr_bank]=1 while din_en=1 is an error.
- Simultaneous events: the write-side set of full[x] and the read-side clear of full[y] in the same edge are legal when x!=y. x=y is impossible per the overrun argument.
- Reset mid-frame: any partial input frame and any in-flight output frame are discarded. The first din_en beat after reset is beat 0 of a new frame.
- Arithmetic: pure data movement, no width change or rounding.

Optional Feature:
- Macro: FFT_REORDER_BEAT_IDX_EN.
- Defined:
  - Adds output dout_beat [log2(BEATS)-1:0] = rd_cnt of the current output beat.
  - Adds output dout_eof, high on beat BEATS-1.
  - Both reset to 0 and are 0 when dout_valid=0.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package fft_pkg:
  - Constants: WIDTH_OUT=13, ARRAY_BTF=16, NPOINT=512, BEATS=32, LOG2N=9.
  - Function bitrev9 (generic bitrev over LOG2N).
  - Typedef for a signed sample.
  - Typedef for the reader state enum {IDLE, READ}.
- One sub-module, fft_reorder_bank: a single NPOINT x 2*WIDTH register bank with ARRAY-lane fixed-pattern write and ARRAY-lane row read. Instantiated twice.

Test Plan:
- Index ramp: frame where beat c lane l carries re=c*16+l, im=-(c*16+l) -> output beat 0 lanes 0..3 re = 0,256,128,384; beat r lane l re = bitrev9(r*16+l) for all 512 samples; im is its negation.
- Latency and SOF: drive 32 contiguous beats, last beat at edge t -> dout_valid high for exactly edges t+1..t+32; dout_sof only at t+1.
- Back-to-back: 4 consecutive ramp frames, each offset by +1000 -> 128 contiguous dout_valid cycles with no bubble; dout_sof every 32 cycles; each frame's data is correct.
- Gapped input: din_en toggled 1/0 each cycle over one frame -> output identical to the ramp case; output starts 1 cycle after the 32nd accepted beat.
- Reset mid-operation: assert rstn=0 after 10 input beats and again during output beat 5 -> outputs go to 0 immediately; a fresh full frame afterwards reorders correctly.
- Extremes: all re=-4096, im=4095 -> every output sample is exactly -4096/4095, no sign corruption.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample/state types and index helper for the FFT output reorder slice.
package fft_pkg;

  localparam int WIDTH_OUT = 13;
  localparam int ARRAY_BTF = 16;
  localparam int NPOINT    = 512;
  localparam int BEATS     = NPOINT / ARRAY_BTF;
  localparam int LOG2N     = 9;

  typedef logic signed [WIDTH_OUT-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic logic [LOG2N-1:0] bitrev9(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) r[b] = idx[LOG2N-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of storage: a beat of bit-reversed samples is scattered to natural
// positions on write, and a natural-order row of ARRAY samples is read out combinationally.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_OUT,
  parameter int ARRAY = ARRAY_BTF,
  parameter int DEPTH = 512
) (
  input  logic                                      clk,
  input  logic                                      i_wr_en,
  input  logic [$clog2(DEPTH/ARRAY)-1:0]            i_wr_beat,
  input  logic [WIDTH*ARRAY-1:0]                    i_wr_re,
  input  logic [WIDTH*ARRAY-1:0]                    i_wr_im,
  input  logic [$clog2(DEPTH/ARRAY)-1:0]            i_rd_beat,
  output logic [WIDTH*ARRAY-1:0]                    o_rd_re,
  output logic [WIDTH*ARRAY-1:0]                    o_rd_im
);

  localparam int LOGN = $clog2(DEPTH);

  logic [2*WIDTH-1:0] r_mem [DEPTH];

  function automatic logic [LOGN-1:0] revIdx(input logic [LOGN-1:0] k);
    logic [LOGN-1:0] r;
    r = '0;
    for (int b = 0; b < LOGN; b++) r[b] = k[LOGN-1-b];
    return r;
  endfunction

  // Contents are deliberately not reset; a bank is only read after a full frame lands in it.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int l = 0; l < ARRAY; l++) begin
        r_mem[revIdx(LOGN'(int'(i_wr_beat) * ARRAY + l))] <=
          {i_wr_im[l*WIDTH +: WIDTH], i_wr_re[l*WIDTH +: WIDTH]};
      end
    end
  end

  always_comb begin
    o_rd_re = '0;
    o_rd_im = '0;
    for (int l = 0; l < ARRAY; l++) begin
      o_rd_re[l*WIDTH +: WIDTH] = r_mem[LOGN'(int'(i_rd_beat) * ARRAY + l)][WIDTH-1:0];
      o_rd_im[l*WIDTH +: WIDTH] = r_mem[LOGN'(int'(i_rd_beat) * ARRAY + l)][2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder of bit-reversed FFT output beats into natural frequency order.
// Optional FFT_REORDER_BEAT_IDX_EN adds dout_beat / dout_eof beat-position outputs.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH  = WIDTH_OUT,
  parameter int ARRAY  = ARRAY_BTF,
  parameter int NPOINT = fft_pkg::NPOINT
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  din_en,
  input  logic [WIDTH*ARRAY-1:0]                din_re,
  input  logic [WIDTH*ARRAY-1:0]                din_im,
  output logic                                  dout_valid,
  output logic [WIDTH*ARRAY-1:0]                dout_re,
  output logic [WIDTH*ARRAY-1:0]                dout_im,
  output logic                                  dout_sof
`ifdef FFT_REORDER_BEAT_IDX_EN
  ,
  output logic [$clog2(NPOINT/ARRAY)-1:0]       dout_beat,
  output logic                                  dout_eof
`endif
);

  localparam int NBEAT  = NPOINT / ARRAY;
  localparam int BEAT_W = $clog2(NBEAT);
  localparam int DW     = WIDTH * ARRAY;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

  logic              r_wr_bank;
  logic [BEAT_W-1:0] r_wr_cnt;
  logic              r_rd_bank;
  logic [BEAT_W-1:0] r_rd_cnt;
  logic [1:0]        r_full;
  rd_state_e         r_state;
  rd_state_e         w_state_nxt;

  logic              w_wr_last;
  logic              w_load;
  logic              w_rd_last;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;
  logic [DW-1:0]     w_rd_re0, w_rd_im0, w_rd_re1, w_rd_im1;
  logic [DW-1:0]     w_rd_re, w_rd_im;

  assign w_wr_last  = din_en && (r_wr_cnt == LAST_BEAT);
  // Reading starts on the same edge the reader leaves IDLE, giving one-cycle latency.
  assign w_load     = (r_state == READ) || r_full[r_rd_bank];
  assign w_rd_last  = w_load && (r_rd_cnt == LAST_BEAT);
  assign w_full_set = {w_wr_last && r_wr_bank, w_wr_last && !r_wr_bank};
  assign w_full_clr = {w_rd_last && r_rd_bank, w_rd_last && !r_rd_bank};
  assign w_rd_re    = r_rd_bank ? w_rd_re1 : w_rd_re0;
  assign w_rd_im    = r_rd_bank ? w_rd_im1 : w_rd_im0;

  fft_reorder_bank #(.WIDTH(WIDTH), .ARRAY(ARRAY), .DEPTH(NPOINT)) u_bank0 (
    .clk       (clk),
    .i_wr_en   (din_en && !r_wr_bank),
    .i_wr_beat (r_wr_cnt),
    .i_wr_re   (din_re),
    .i_wr_im   (din_im),
    .i_rd_beat (r_rd_cnt),
    .o_rd_re   (w_rd_re0),
    .o_rd_im   (w_rd_im0)
  );

  fft_reorder_bank #(.WIDTH(WIDTH), .ARRAY(ARRAY), .DEPTH(NPOINT)) u_bank1 (
    .clk       (clk),
    .i_wr_en   (din_en && r_wr_bank),
    .i_wr_beat (r_wr_cnt),
    .i_wr_re   (din_re),
    .i_wr_im   (din_im),
    .i_rd_beat (r_rd_cnt),
    .o_rd_re   (w_rd_re1),
    .o_rd_im   (w_rd_im1)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_full    <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
      if (din_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (r_full[r_rd_bank]) w_state_nxt = READ;
      READ: begin
        // Zero-gap continuation when the other bank is already (or just became) full.
        if (w_rd_last)
          w_state_nxt = (r_full[~r_rd_bank] || w_full_set[~r_rd_bank]) ? READ : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      dout_valid <= w_load;
      dout_sof   <= w_load && (r_rd_cnt == '0);
      if (w_load) begin
        dout_re  <= w_rd_re;
        dout_im  <= w_rd_im;
        r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

`ifdef FFT_REORDER_BEAT_IDX_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_beat <= '0;
      dout_eof  <= 1'b0;
    end else begin
      dout_beat <= w_load ? r_rd_cnt : '0;
      dout_eof  <= w_rd_last;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overrun: assert property (@(posedge clk) disable iff (!rstn)
    !(din_en && r_full[r_wr_bank]));
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomised self-checking bench for fft_out_reorder against a frame-level queue model.
module tb_fft_out_reorder;

  localparam int W  = 13;
  localparam int A  = 16;
  localparam int N  = 512;
  localparam int NB = N / A;
  localparam int DW = W * A;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          din_en = 1'b0;
  logic [DW-1:0] din_re = '0;
  logic [DW-1:0] din_im = '0;
  logic          dout_valid;
  logic [DW-1:0] dout_re;
  logic [DW-1:0] dout_im;
  logic          dout_sof;
`ifdef FFT_REORDER_BEAT_IDX_EN
  logic [4:0]    dout_beat;
  logic          dout_eof;
`endif

  always #5 clk = ~clk;

  fft_out_reorder dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_en     (din_en),
    .din_re     (din_re),
    .din_im     (din_im),
    .dout_valid (dout_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_sof   (dout_sof)
`ifdef FFT_REORDER_BEAT_IDX_EN
    ,
    .dout_beat  (dout_beat),
    .dout_eof   (dout_eof)
`endif
  );

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sof;
    int            beat;
  } beat_t;

  beat_t expQ[$];
  int    frmRe[N];
  int    frmIm[N];
  int    laneRe[A];
  int    laneIm[A];
  int    inBeats = 0;
  int    testsRun = 0;
  int    testsFailed = 0;
  int    runLen = 0;
  int    lastRun = 0;
  bit    checkHead = 1'b0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic int revIdx(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 9; b++) if (((k >> b) & 1) != 0) r = r + (1 << (8 - b));
    return r;
  endfunction

  // A completed frame becomes 32 natural-order beats: input position p lands at index revIdx(p).
  task automatic modelFrame();
    int    natRe[N];
    int    natIm[N];
    beat_t b;
    for (int p = 0; p < N; p++) begin
      natRe[revIdx(p)] = frmRe[p];
      natIm[revIdx(p)] = frmIm[p];
    end
    for (int r = 0; r < NB; r++) begin
      b.re = '0;
      b.im = '0;
      for (int l = 0; l < A; l++) begin
        b.re[l*W +: W] = W'(natRe[r*A + l]);
        b.im[l*W +: W] = W'(natIm[r*A + l]);
      end
      b.sof  = (r == 0);
      b.beat = r;
      expQ.push_back(b);
    end
  endtask

  task automatic sampleOutputs();
    beat_t e;
    bit    expV;
    int    headExp[4];
    headExp = '{0, 256, 128, 384};
    expV = (expQ.size() > 0);
    checkOutput("valid", DW'(dout_valid), DW'(expV));
    if (expV) begin
      e = expQ.pop_front();
      checkOutput("re", dout_re, e.re);
      checkOutput("im", dout_im, e.im);
      checkOutput("sof", DW'(dout_sof), DW'(e.sof));
`ifdef FFT_REORDER_BEAT_IDX_EN
      checkOutput("beat", DW'(dout_beat), DW'(e.beat));
      checkOutput("eof", DW'(dout_eof), DW'(e.beat == NB - 1));
`endif
      if (checkHead && e.sof) begin
        checkHead = 1'b0;
        for (int l = 0; l < 4; l++) checkOutput("headLane", DW'(dout_re[l*W +: W]), DW'(headExp[l]));
      end
    end else begin
      checkOutput("sofIdle", DW'(dout_sof), '0);
`ifdef FFT_REORDER_BEAT_IDX_EN
      checkOutput("beatIdle", DW'(dout_beat), '0);
      checkOutput("eofIdle", DW'(dout_eof), '0);
`endif
    end
    if (dout_valid) runLen++;
    else begin
      if (runLen > 0) lastRun = runLen;
      runLen = 0;
    end
  endtask

  // One clock: drive at the falling edge, observe 1 time unit after the rising edge.
  task automatic applyStimulus(input bit en);
    din_en = en;
    for (int l = 0; l < A; l++) begin
      din_re[l*W +: W] = W'(laneRe[l]);
      din_im[l*W +: W] = W'(laneIm[l]);
    end
    @(posedge clk);
    #1;
    sampleOutputs();
    if (en) begin
      for (int l = 0; l < A; l++) begin
        frmRe[inBeats*A + l] = laneRe[l];
        frmIm[inBeats*A + l] = laneIm[l];
      end
      inBeats++;
      if (inBeats == NB) begin
        modelFrame();
        inBeats = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic rampBeat(input int c, input int off);
    for (int l = 0; l < A; l++) begin
      laneRe[l] = c * A + l + off;
      laneIm[l] = -(c * A + l + off);
    end
  endtask

  task automatic sendRamp(input int off, input bit gapped, input int nBeats);
    for (int c = 0; c < nBeats; c++) begin
      rampBeat(c, off);
      applyStimulus(1'b1);
      if (gapped) applyStimulus(1'b0);
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    #1;
    checkOutput("rstValid", DW'(dout_valid), '0);
    checkOutput("rstSof", DW'(dout_sof), '0);
    checkOutput("rstRe", dout_re, '0);
    checkOutput("rstIm", dout_im, '0);
    expQ.delete();
    inBeats = 0;
    runLen  = 0;
    din_en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    doReset();
    idle(2);

    checkHead = 1'b1;
    sendRamp(0, 1'b0, NB);
    idle(34);
    checkOutput("runSingle", DW'(lastRun), DW'(32));
    checkOutput("headSeen", DW'(checkHead), '0);

    for (int f = 0; f < 4; f++) sendRamp(f * 1000, 1'b0, NB);
    idle(34);
    checkOutput("runBackToBack", DW'(lastRun), DW'(128));

    sendRamp(0, 1'b1, NB);
    idle(34);
    checkOutput("runGapped", DW'(lastRun), DW'(32));

    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < NB; c++) begin
        for (int l = 0; l < A; l++) begin
          laneRe[l] = int'($urandom_range(0, 8191)) - 4096;
          laneIm[l] = int'($urandom_range(0, 8191)) - 4096;
        end
        applyStimulus(1'b1);
        if ($urandom_range(0, 2) == 0) applyStimulus(1'b0);
      end
    end
    idle(40);

    sendRamp(0, 1'b0, 10);
    doReset();
    sendRamp(7, 1'b0, NB);
    idle(6);
    doReset();
    sendRamp(11, 1'b0, NB);
    idle(34);
    checkOutput("runAfterReset", DW'(lastRun), DW'(32));

    for (int l = 0; l < A; l++) begin
      laneRe[l] = -4096;
      laneIm[l] = 4095;
    end
    for (int c = 0; c < NB; c++) applyStimulus(1'b1);
    idle(34);
    checkOutput("queueDrained", DW'(expQ.size()), '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
